fan_cfg_sequencer: RTL and testbench
====================================

Name: fan_cfg_sequencer

Overview:
- Byte-serial configuration front end for the fan controller. Accepts command/payload bytes from the 8-bit input pins with a strobe pin, assembles them into shadow registers and atomically commits them to the active PID coefficient, set-point and PWM limit outputs.
- Drives the fan controller's config-mode and data-strobe control inputs, so the PID datapath only ever sees complete coefficient sets.

Parameters:
- ADC_BITWIDTH, 8, width of set-point and PWM minimum; PWM period is ADC_BITWIDTH+1 bits.
- REG_BITWIDTH, 32, PID coefficient width; must be a multiple of 8.
- TIMEOUT_CYCLES, 1000000, idle clk_i cycles before an incomplete payload is aborted.
- PERIOD_RST, 255, reset value of the active and shadow PWM period.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  asynchronous active-low reset
- data_i  in  8  byte from input pins; stable from before strb_i rise until 4 clk_i after it
- strb_i  in  1  raw byte strobe pin, asynchronous; one byte per rising edge
- a0_o, a1_o, b0_o, b1_o, b2_o  out  REG_BITWIDTH each  active signed PID coefficients
- set_value_o  out  ADC_BITWIDTH  active set-point
- pwm_period_o  out  ADC_BITWIDTH+1  active PWM period counter value
- pwm_min_o  out  ADC_BITWIDTH  active PWM minimum counter value
- config_en_o  out  1  fan controller config mode
- data_valid_strb_o  out  1  one-cycle strobe to fan controller on commit
- busy_o  out  1  high while a payload is being received
- err_o  out  1  sticky error flag

Behaviour:
Reset (async, all state):
- All coefficients, set_value_o and pwm_min_o = 0; pwm_period_o = PERIOD_RST; shadows are equal to the active values.
- config_en_o = 1, data_valid_strb_o = 0, busy_o = 0, err_o = 0; FSM in IDLE; timeout counter = 0.
- Reset mid-payload discards the partial data.

Strobe front end:
- strb_i passes through a 2-FF synchronizer plus an edge register; the rising edge yields a one-cycle byte_ev.
- data_i is sampled on the byte_ev cycle, 3 clk_i after the strb_i rise.

Header byte (accepted only in IDLE), upper nibble must be 4'hA:
- idx 0..4 = a0, a1, b0, b1, b2: REG_BITWIDTH/8 payload bytes, MSB first.
- idx 5 = SET: 1 byte.
- idx 6 = PERIOD: 2 bytes, high byte first; only bit0 of the high byte is used.
- idx 7 = MIN: 1 byte.
- idx 8 = ENTER_CFG: no payload; config_en_o = 1 on the cycle after byte_ev.
- idx 9 = COMMIT: no payload; on the cycle after byte_ev all shadows are copied to the active outputs in one cycle, data_valid_strb_o pulses for 1 cycle and config_en_o = 0.
- Wrong nibble or idx >= 10: err_o = 1, state stays IDLE.
- Any valid header clears err_o.

FSM:
- IDLE -> PAYLOAD on a payload-bearing header; the remaining-byte counter is loaded and busy_o = 1.
- PAYLOAD: each byte_ev shifts into the assembly register and decrements the counter. On the last byte the target shadow is written on the next cycle, the FSM returns to IDLE and busy_o = 0.
- Shadows are never partially written.
- Shadow writes are allowed regardless of config_en_o. Active outputs change only on COMMIT.

Timeout:
- The counter runs in PAYLOAD and is cleared on each byte_ev and in IDLE.
- On reaching TIMEOUT_CYCLES-1 the FSM aborts to IDLE with err_o = 1, busy_o = 0, and the shadow is unchanged.
- If byte_ev and expiry occur in the same cycle, the byte wins: it is accepted and the counter is cleared.

Other rules:
- COMMIT while config_en_o = 0 still copies the shadows and pulses the strobe.
- Consecutive COMMITs each pulse data_valid_strb_o.
- A second strb_i rise before the previous edge is detected (closer than 3 clk_i) is not supported.

Test Plan:
- Reset -> a0_o..b2_o = 0, pwm_period_o = 255, config_en_o = 1, err_o = 0, busy_o = 0.
- Header 0xA2, bytes 12 34 56 78, then 0xA9 -> b0_o = 32'h12345678 only after 0xA9; one data_valid_strb_o pulse; config_en_o = 0; b0_o unchanged before the commit.
- Header 0xA6, bytes 01 8F, 0xA9 -> pwm_period_o = 9'h18F. Header 0xA8 -> config_en_o = 1 with outputs unchanged.
- Header 0xA0, 2 bytes, then silence for TIMEOUT_CYCLES (set to 100 in the bench) -> err_o = 1, busy_o = 0, FSM in IDLE. Next 0xA9 -> a0_o unchanged, err_o = 0.
- Byte 0x5F, then 0xAB -> err_o = 1 after each. 0xA5 followed by 0x80 then 0xA9 -> err_o = 0 and set_value_o = 8'h80.
- rstn_i asserted after the 3rd byte of an a1 payload -> everything returns to reset values. A full a1 load and commit afterwards works.

Source files
------------

// File: rtl/fan_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fan_cfg_sequencer
// Description : Byte-serial configuration front end for the fan controller.
//               Assembles header/payload bytes into shadow registers and
//               commits them atomically to the active PID/PWM outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module fan_cfg_sequencer #(
    parameter int ADC_BITWIDTH   = 8,
    parameter int REG_BITWIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int PERIOD_RST     = 255
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [7:0]              data_i,
    input  logic                    strb_i,
    output logic [REG_BITWIDTH-1:0] a0_o,
    output logic [REG_BITWIDTH-1:0] a1_o,
    output logic [REG_BITWIDTH-1:0] b0_o,
    output logic [REG_BITWIDTH-1:0] b1_o,
    output logic [REG_BITWIDTH-1:0] b2_o,
    output logic [ADC_BITWIDTH-1:0] set_value_o,
    output logic [ADC_BITWIDTH:0]   pwm_period_o,
    output logic [ADC_BITWIDTH-1:0] pwm_min_o,
    output logic                    config_en_o,
    output logic                    data_valid_strb_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int c_REG_BYTES = REG_BITWIDTH / 8;
    localparam int c_MAX_LEN   = (c_REG_BYTES > 2) ? c_REG_BYTES : 2;
    localparam int c_CNT_W     = $clog2(c_MAX_LEN + 1);
    localparam int c_TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_CNT_W-1:0]    c_LEN_REG    = c_REG_BYTES[c_CNT_W-1:0];
    localparam logic [c_CNT_W-1:0]    c_LEN_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]    c_LEN_TWO    = c_CNT_W'(2);
    localparam logic [c_TMO_W-1:0]    c_TMO_LAST   = c_TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADC_BITWIDTH:0] c_PERIOD_RST = PERIOD_RST[ADC_BITWIDTH:0];

    localparam logic [3:0] c_IDX_SET    = 4'd5;
    localparam logic [3:0] c_IDX_PERIOD = 4'd6;
    localparam logic [3:0] c_IDX_MIN    = 4'd7;
    localparam logic [3:0] c_IDX_ENTER  = 4'd8;
    localparam logic [3:0] c_IDX_COMMIT = 4'd9;

    localparam logic [0:0] c_S_IDLE    = 1'b0;
    localparam logic [0:0] c_S_PAYLOAD = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic                    r_strb_meta;
    logic                    r_strb_sync;
    logic                    r_strb_d;
    logic                    w_byte_ev;
    logic [c_CNT_W-1:0]      r_remain;
    logic [3:0]              r_target;
    logic [REG_BITWIDTH-1:0] r_asm;
    logic [REG_BITWIDTH-1:0] w_asm_shift;
    logic [c_TMO_W-1:0]      r_tmo;

    logic                    w_hdr_ok;
    logic                    w_hdr_bad;
    logic                    w_start;
    logic                    w_enter;
    logic                    w_commit;
    logic                    w_last;
    logic                    w_abort;
    logic [c_CNT_W-1:0]      w_len;

    logic [REG_BITWIDTH-1:0] r_sh_a0, r_sh_a1, r_sh_b0, r_sh_b1, r_sh_b2;
    logic [ADC_BITWIDTH-1:0] r_sh_set;
    logic [ADC_BITWIDTH:0]   r_sh_period;
    logic [ADC_BITWIDTH-1:0] r_sh_min;

    // Strobe pin is asynchronous: two flops for metastability, one for edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_strb_meta <= 1'b0;
            r_strb_sync <= 1'b0;
            r_strb_d    <= 1'b0;
        end else begin
            r_strb_meta <= strb_i;
            r_strb_sync <= r_strb_meta;
            r_strb_d    <= r_strb_sync;
        end
    end

    assign w_byte_ev   = r_strb_sync & ~r_strb_d;
    assign w_asm_shift = REG_BITWIDTH'({r_asm, data_i});
    assign busy_o      = (r_state == c_S_PAYLOAD);

    always_comb begin
        w_state_nxt = r_state;
        w_hdr_ok    = 1'b0;
        w_hdr_bad   = 1'b0;
        w_start     = 1'b0;
        w_enter     = 1'b0;
        w_commit    = 1'b0;
        w_last      = 1'b0;
        w_abort     = 1'b0;
        w_len       = '0;
        case (r_state)
            c_S_IDLE: begin
                if (w_byte_ev) begin
                    if ((data_i[7:4] == 4'hA) && (data_i[3:0] < 4'd10)) begin
                        w_hdr_ok = 1'b1;
                        case (data_i[3:0])
                            c_IDX_SET:    w_len = c_LEN_ONE;
                            c_IDX_PERIOD: w_len = c_LEN_TWO;
                            c_IDX_MIN:    w_len = c_LEN_ONE;
                            c_IDX_ENTER:  w_enter = 1'b1;
                            c_IDX_COMMIT: w_commit = 1'b1;
                            default:      w_len = c_LEN_REG;
                        endcase
                        if (data_i[3:0] < c_IDX_ENTER) begin
                            w_start     = 1'b1;
                            w_state_nxt = c_S_PAYLOAD;
                        end
                    end else begin
                        w_hdr_bad = 1'b1;
                    end
                end
            end
            c_S_PAYLOAD: begin
                // A byte arriving on the expiry cycle takes priority.
                if (w_byte_ev) begin
                    if (r_remain == c_LEN_ONE) begin
                        w_last      = 1'b1;
                        w_state_nxt = c_S_IDLE;
                    end
                end else if (r_tmo == c_TMO_LAST) begin
                    w_abort     = 1'b1;
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state  <= c_S_IDLE;
            r_remain <= '0;
            r_target <= '0;
            r_asm    <= '0;
            r_tmo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_remain <= w_len;
                r_target <= data_i[3:0];
                r_asm    <= '0;
            end else if ((r_state == c_S_PAYLOAD) && w_byte_ev) begin
                r_remain <= r_remain - c_LEN_ONE;
                r_asm    <= w_asm_shift;
            end
            if ((r_state == c_S_IDLE) || w_byte_ev) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // Shadows are written whole, only when the final payload byte lands.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sh_a0     <= '0;
            r_sh_a1     <= '0;
            r_sh_b0     <= '0;
            r_sh_b1     <= '0;
            r_sh_b2     <= '0;
            r_sh_set    <= '0;
            r_sh_period <= c_PERIOD_RST;
            r_sh_min    <= '0;
        end else if (w_last) begin
            case (r_target)
                4'd0:         r_sh_a0     <= w_asm_shift;
                4'd1:         r_sh_a1     <= w_asm_shift;
                4'd2:         r_sh_b0     <= w_asm_shift;
                4'd3:         r_sh_b1     <= w_asm_shift;
                4'd4:         r_sh_b2     <= w_asm_shift;
                c_IDX_SET:    r_sh_set    <= w_asm_shift[ADC_BITWIDTH-1:0];
                c_IDX_PERIOD: r_sh_period <= w_asm_shift[ADC_BITWIDTH:0];
                c_IDX_MIN:    r_sh_min    <= w_asm_shift[ADC_BITWIDTH-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            a0_o              <= '0;
            a1_o              <= '0;
            b0_o              <= '0;
            b1_o              <= '0;
            b2_o              <= '0;
            set_value_o       <= '0;
            pwm_period_o      <= c_PERIOD_RST;
            pwm_min_o         <= '0;
            config_en_o       <= 1'b1;
            data_valid_strb_o <= 1'b0;
            err_o             <= 1'b0;
        end else begin
            data_valid_strb_o <= w_commit;
            if (w_commit) begin
                a0_o         <= r_sh_a0;
                a1_o         <= r_sh_a1;
                b0_o         <= r_sh_b0;
                b1_o         <= r_sh_b1;
                b2_o         <= r_sh_b2;
                set_value_o  <= r_sh_set;
                pwm_period_o <= r_sh_period;
                pwm_min_o    <= r_sh_min;
                config_en_o  <= 1'b0;
            end else if (w_enter) begin
                config_en_o <= 1'b1;
            end
            if (w_hdr_bad || w_abort) begin
                err_o <= 1'b1;
            end else if (w_hdr_ok) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fan_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fan_cfg_sequencer
// Description : Randomized self-checking bench for fan_cfg_sequencer against
//               a byte-level reference model of the command protocol.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fan_cfg_sequencer;

    localparam int c_TMO = 100;

    logic        clk_i  = 1'b0;
    logic        rstn_i = 1'b0;
    logic [7:0]  data_i = 8'h00;
    logic        strb_i = 1'b0;
    logic [31:0] a0_o, a1_o, b0_o, b1_o, b2_o;
    logic [7:0]  set_value_o;
    logic [8:0]  pwm_period_o;
    logic [7:0]  pwm_min_o;
    logic        config_en_o, data_valid_strb_o, busy_o, err_o;

    fan_cfg_sequencer #(
        .ADC_BITWIDTH  (8),
        .REG_BITWIDTH  (32),
        .TIMEOUT_CYCLES(c_TMO),
        .PERIOD_RST    (255)
    ) u_dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .data_i           (data_i),
        .strb_i           (strb_i),
        .a0_o             (a0_o),
        .a1_o             (a1_o),
        .b0_o             (b0_o),
        .b1_o             (b1_o),
        .b2_o             (b2_o),
        .set_value_o      (set_value_o),
        .pwm_period_o     (pwm_period_o),
        .pwm_min_o        (pwm_min_o),
        .config_en_o      (config_en_o),
        .data_valid_strb_o(data_valid_strb_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    int strb_cnt = 0;

    // Cycles with the commit strobe high; a stretched pulse counts twice.
    always @(negedge clk_i) if (data_valid_strb_o) strb_cnt++;

    // Reference model: index 0..4 coefficients, 5 set, 6 period, 7 min.
    logic [31:0] m_shd [8];
    logic [31:0] m_act [8];
    logic        m_cfg;
    logic        m_err;
    int          m_len;
    int          m_tgt;
    int          m_commits = 0;
    logic [7:0]  m_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_shd[i] = (i == 6) ? 32'd255 : 32'd0;
            m_act[i] = m_shd[i];
        end
        m_cfg = 1'b1;
        m_err = 1'b0;
        m_len = 0;
        m_tgt = 0;
        m_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [31:0] val;
        int          idx;
        if (m_len == 0) begin
            idx = int'(b[3:0]);
            if (b[7:4] == 4'hA && idx < 10) begin
                m_err = 1'b0;
                m_q.delete();
                m_tgt = idx;
                if (idx < 5)       m_len = 4;
                else if (idx == 6) m_len = 2;
                else if (idx < 8)  m_len = 1;
                else if (idx == 8) m_cfg = 1'b1;
                else begin
                    for (int i = 0; i < 8; i++) m_act[i] = m_shd[i];
                    m_cfg = 1'b0;
                    m_commits++;
                end
            end else begin
                m_err = 1'b1;
            end
        end else begin
            m_q.push_back(b);
            if (m_q.size() == m_len) begin
                val = 0;
                foreach (m_q[i]) val = val * 256 + 32'(m_q[i]);
                if (m_tgt == 6) val = val % 512;
                m_shd[m_tgt] = val;
                m_len = 0;
            end
        end
    endtask

    task automatic model_timeout();
        m_len = 0;
        m_err = 1'b1;
        m_q.delete();
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".a0"}, 64'(a0_o), 64'(m_act[0]));
        check({ctx, ".a1"}, 64'(a1_o), 64'(m_act[1]));
        check({ctx, ".b0"}, 64'(b0_o), 64'(m_act[2]));
        check({ctx, ".b1"}, 64'(b1_o), 64'(m_act[3]));
        check({ctx, ".b2"}, 64'(b2_o), 64'(m_act[4]));
        check({ctx, ".set"}, 64'(set_value_o), 64'(m_act[5]));
        check({ctx, ".period"}, 64'(pwm_period_o), 64'(m_act[6]));
        check({ctx, ".min"}, 64'(pwm_min_o), 64'(m_act[7]));
        check({ctx, ".cfg"}, 64'(config_en_o), 64'(m_cfg));
        check({ctx, ".busy"}, 64'(busy_o), 64'(m_len != 0));
        check({ctx, ".err"}, 64'(err_o), 64'(m_err));
        check({ctx, ".strb_cnt"}, 64'(strb_cnt), 64'(m_commits));
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_i);
        data_i = b;
        @(negedge clk_i);
        strb_i = 1'b1;
        repeat (6) @(negedge clk_i);
        strb_i = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic xfer(input logic [7:0] b, input string ctx);
        send_byte(b);
        model_byte(b);
        check_all(ctx);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rstn_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        model_reset();
        @(negedge clk_i);
    endtask

    initial begin
        logic [7:0] b;
        int         op, n, idx;

        model_reset();
        repeat (3) @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        check_all("reset");
        check("reset.strobe", 64'(data_valid_strb_o), 64'd0);

        // b0 load then commit
        xfer(8'hA2, "b0.hdr");
        xfer(8'h12, "b0.p0");
        xfer(8'h34, "b0.p1");
        xfer(8'h56, "b0.p2");
        xfer(8'h78, "b0.p3");
        check("b0.pre_commit", 64'(b0_o), 64'd0);
        xfer(8'hA9, "b0.commit");
        check("b0.value", 64'(b0_o), 64'h12345678);
        check("b0.cfg_off", 64'(config_en_o), 64'd0);

        // period load, commit, then enter config
        xfer(8'hA6, "per.hdr");
        xfer(8'h01, "per.hi");
        xfer(8'h8F, "per.lo");
        xfer(8'hA9, "per.commit");
        check("per.value", 64'(pwm_period_o), 64'h18F);
        xfer(8'hA8, "enter");

        // timeout abort with partial a0 payload
        xfer(8'hA0, "tmo.hdr");
        xfer(8'hDE, "tmo.p0");
        xfer(8'hAD, "tmo.p1");
        repeat (80) @(negedge clk_i);
        check("tmo.still_busy", 64'(busy_o), 64'd1);
        repeat (30) @(negedge clk_i);
        model_timeout();
        check_all("tmo.abort");
        xfer(8'hA9, "tmo.commit");

        // bad headers then set-point
        xfer(8'h5F, "bad.nib");
        xfer(8'hAB, "bad.idx");
        xfer(8'hA5, "set.hdr");
        xfer(8'h80, "set.p0");
        xfer(8'hA9, "set.commit");
        check("set.value", 64'(set_value_o), 64'h80);

        // reset in the middle of an a1 payload
        xfer(8'hA1, "rst.hdr");
        xfer(8'h11, "rst.p0");
        xfer(8'h22, "rst.p1");
        xfer(8'h33, "rst.p2");
        do_reset();
        check_all("rst.after");
        xfer(8'hA1, "a1.hdr");
        xfer(8'hCA, "a1.p0");
        xfer(8'hFE, "a1.p1");
        xfer(8'hBA, "a1.p2");
        xfer(8'hBE, "a1.p3");
        xfer(8'hA9, "a1.commit");
        check("a1.value", 64'(a1_o), 64'hCAFEBABE);

        // randomized command mix
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            if (op < 5) begin
                idx = $urandom_range(0, 7);
                xfer(8'hA0 | 8'(idx), "rnd.hdr");
                n = (idx < 5) ? 4 : (idx == 6) ? 2 : 1;
                for (int k = 0; k < n; k++) xfer(8'($urandom), "rnd.pay");
            end else if (op < 7) begin
                xfer(8'hA9, "rnd.commit");
            end else if (op == 7) begin
                xfer(8'hA8, "rnd.enter");
            end else if (op == 8) begin
                b = 8'($urandom);
                while (b[7:4] == 4'hA && b[3:0] < 4'd10) b = 8'($urandom);
                xfer(b, "rnd.bad");
            end else begin
                idx = $urandom_range(0, 4);
                xfer(8'hA0 | 8'(idx), "rnd.thdr");
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) xfer(8'($urandom), "rnd.tpay");
                repeat (c_TMO + 20) @(negedge clk_i);
                model_timeout();
                check_all("rnd.tmo");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
